// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and constants for the IF/MEM unified memory arbiter.
package unified_mem_arbiter_pkg;

  // Arbiter FSM states; also exported on the debug port.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IF   = 2'd1,
    ARB_DM   = 2'd2
  } arb_state_e;

  // DMType code for a full 32-bit word access; fetches always use it.
  localparam logic [2:0] DM_WORD = 3'b000;

  // Width of the starvation counter (limit range is 1..15).
  localparam int unsigned STARVE_W = 4;

  // The data side wins unless fetch is also waiting and has lost too many
  // arbitrations in a row.
  function automatic logic dm_wins(input logic                dm_req,
                                   input logic                if_req,
                                   input logic [STARVE_W-1:0] starve_cnt,
                                   input logic [STARVE_W-1:0] starve_limit);
    return dm_req & (~if_req | (starve_cnt < starve_limit));
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_wait_timer.sv
// Counts cycles spent waiting on the memory and flags the last allowed cycle.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned   CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: cleared while idle, saturating increment while waiting.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expired during the TIMEOUT-th waiting cycle (count TIMEOUT-1).
  assign expired_o = enable_i & ~clear_i & (count_q == LAST);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported variable-latency memory between instruction
// fetch (IF) and load/store (DM). One access in flight at a time.
//
// Handshake: a requester raises *_req with its payload and holds both until
// its *_ready pulses for one cycle. The memory side sees mem_req held high
// with stable mem_* until a one-cycle mem_ack; mem_rdata is valid with it.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [2:0]  dm_type,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        stall_if,
  output logic        stall_dm,
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  mem_type,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err,
  output logic [1:0]  dbg_state
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_e          state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [2:0]          mem_type_q, mem_type_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                bus_err_q, bus_err_d;

  logic                busy;
  logic                expired;

  assign busy = (state_q != ARB_IDLE);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i     (clk),
    .rst_i     (reset),
    .clear_i   (~busy),
    .enable_i  (busy),
    .expired_o (expired)
  );

  // Next state, arbitration, mem_* latching and per-requester completion.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_type_d  = mem_type_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    starve_d    = starve_q;
    bus_err_d   = bus_err_q;
    if_ready    = 1'b0;
    dm_ready    = 1'b0;
    if_rdata    = 32'h0;
    dm_rdata    = 32'h0;

    unique case (state_q)
      ARB_IDLE: begin
        if (dm_wins(dm_req, if_req, starve_q, STARVE_MAX)) begin
          state_d     = ARB_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_type_d  = dm_type;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          // Fetch lost this round; count it toward the forced IF win.
          if (if_req && (starve_q < STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
          end
        end else if (if_req) begin
          state_d     = ARB_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_type_d  = DM_WORD;
          mem_addr_d  = if_addr;
          mem_wdata_d = 32'h0;
          starve_d    = '0;
        end
      end

      ARB_IF, ARB_DM: begin
        // Completion on ack, or abort when the wait timer runs out; the ack
        // takes precedence if both land in the same cycle.
        if (mem_ack || expired) begin
          if (state_q == ARB_IF) begin
            if_ready = 1'b1;
            if_rdata = mem_ack ? mem_rdata : 32'h0;
          end else begin
            dm_ready = 1'b1;
            dm_rdata = (mem_ack && !mem_we_q) ? mem_rdata : 32'h0;
          end
          if (!mem_ack) begin
            bus_err_d = 1'b1;
          end
          state_d   = ARB_IDLE;
          mem_req_d = 1'b0;
        end
      end

      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and memory-interface registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_type_q  <= 3'b000;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      starve_q    <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_type_q  <= mem_type_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      starve_q    <= starve_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign stall_if  = if_req & ~if_ready;
  assign stall_dm  = dm_req & ~dm_ready;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_type  = mem_type_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign bus_err   = bus_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter (STARVE_LIMIT=4, TIMEOUT=8).
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [2:0]  dm_type;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        stall_if;
  logic        stall_dm;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_type;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_err;
  logic [1:0]  dbg_state;

  unified_mem_arbiter #(
    .STARVE_LIMIT (4),
    .TIMEOUT      (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_type   (dm_type),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .stall_if  (stall_if),
    .stall_dm  (stall_dm),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_type  (mem_type),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .bus_err   (bus_err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    if_req    = 1'b0;
    if_addr   = 32'h0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_type   = 3'b000;
    dm_addr   = 32'h0;
    dm_wdata  = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [2:0]  dm_type;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    int          ack_dly;
    logic [31:0] rdata;
    logic        exp_dm;
    logic        exp_we;
    logic [2:0]  exp_type;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  // One arbitration from IDLE: request, grant, wait, ack, return to IDLE.
  task automatic run_vec(input vec_t v);
    if_req   = v.if_req;
    if_addr  = v.if_addr;
    dm_req   = v.dm_req;
    dm_we    = v.dm_we;
    dm_type  = v.dm_type;
    dm_addr  = v.dm_addr;
    dm_wdata = v.dm_wdata;
    #1;
    chk("idle_mem_req", {31'h0, mem_req}, 32'h0);
    chk("idle_stall_if", {31'h0, stall_if}, {31'h0, v.if_req});
    chk("idle_stall_dm", {31'h0, stall_dm}, {31'h0, v.dm_req});
    step();
    chk("grant_mem_req", {31'h0, mem_req}, 32'h1);
    chk("grant_mem_we", {31'h0, mem_we}, {31'h0, v.exp_we});
    chk("grant_mem_type", {29'h0, mem_type}, {29'h0, v.exp_type});
    chk("grant_mem_addr", mem_addr, v.exp_addr);
    chk("grant_mem_wdata", mem_wdata, v.exp_wdata);
    for (int d = 0; d < v.ack_dly; d++) begin
      chk("wait_readies", {30'h0, if_ready, dm_ready}, 32'h0);
      step();
    end
    chk("wait_mem_addr_stable", mem_addr, v.exp_addr);
    mem_ack   = 1'b1;
    mem_rdata = v.rdata;
    #1;
    chk("ack_if_ready", {31'h0, if_ready}, {31'h0, ~v.exp_dm});
    chk("ack_dm_ready", {31'h0, dm_ready}, {31'h0, v.exp_dm});
    chk("ack_if_rdata", if_rdata, v.exp_dm ? 32'h0 : v.exp_rdata);
    chk("ack_dm_rdata", dm_rdata, v.exp_dm ? v.exp_rdata : 32'h0);
    chk("ack_stall_if", {31'h0, stall_if}, {31'h0, v.if_req & v.exp_dm});
    chk("ack_stall_dm", {31'h0, stall_dm}, {31'h0, v.dm_req & ~v.exp_dm});
    step();
    idle_inputs();
    #1;
    chk("done_mem_req", {31'h0, mem_req}, 32'h0);
    chk("done_state", {30'h0, dbg_state}, 32'h0);
  endtask

  // ---------------- test ----------------
  initial begin
    //            ifr  if_addr       dmr  we    type    dm_addr       dm_wdata      dly rdata         dm   ewe   etype   eaddr         ewdata        erdata
    vecs[0] = '{1'b1, 32'h0000_0000, 1'b0, 1'b0, 3'b000, 32'h0,        32'h0,        0, 32'h0000_0013, 1'b0, 1'b0, 3'b000, 32'h0000_0000, 32'h0,        32'h0000_0013};
    vecs[1] = '{1'b0, 32'h0,        1'b1, 1'b0, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF, 1, 32'h1234_5678, 1'b1, 1'b0, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF, 32'h1234_5678};
    vecs[2] = '{1'b0, 32'h0,        1'b1, 1'b1, 3'b000, 32'h2000_0008, 32'hCAFE_F00D, 2, 32'h5555_AAAA, 1'b1, 1'b1, 3'b000, 32'h2000_0008, 32'hCAFE_F00D, 32'h0};
    vecs[3] = '{1'b1, 32'h0000_0040, 1'b1, 1'b0, 3'b100, 32'h0000_0080, 32'h0,        0, 32'hA5A5_0001, 1'b1, 1'b0, 3'b100, 32'h0000_0080, 32'h0,        32'hA5A5_0001};
    vecs[4] = '{1'b1, 32'h0000_0044, 1'b0, 1'b1, 3'b111, 32'h0000_0F00, 32'h1111_2222, 3, 32'h0000_0093, 1'b0, 1'b0, 3'b000, 32'h0000_0044, 32'h0,        32'h0000_0093};
    vecs[5] = '{1'b1, 32'h0000_0048, 1'b1, 1'b1, 3'b001, 32'h0000_3004, 32'h0000_FFFF, 1, 32'h0000_0099, 1'b1, 1'b1, 3'b001, 32'h0000_3004, 32'h0000_FFFF, 32'h0};

    idle_inputs();
    reset = 1'b1;
    step();
    step();
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
    chk("rst_readies", {30'h0, if_ready, dm_ready}, 32'h0);
    chk("rst_state", {30'h0, dbg_state}, 32'h0);
    reset = 1'b0;
    step();

    // Single arbitrations from the table.
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
    end

    // Both request, DM store first with ack delay 2, then IF after one idle cycle.
    if_req   = 1'b1;
    if_addr  = 32'h0000_0100;
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_type  = 3'b001;
    dm_addr  = 32'h0000_0300;
    dm_wdata = 32'h0BAD_F00D;
    #1;
    chk("both_stall_if0", {31'h0, stall_if}, 32'h1);
    step();
    chk("both_dm_addr", mem_addr, 32'h0000_0300);
    chk("both_dm_we", {31'h0, mem_we}, 32'h1);
    step();
    chk("both_stall_if1", {31'h0, stall_if}, 32'h1);
    step();
    mem_ack = 1'b1;
    #1;
    chk("both_dm_ready", {31'h0, dm_ready}, 32'h1);
    chk("both_dm_rdata_store", dm_rdata, 32'h0);
    chk("both_stall_if2", {31'h0, stall_if}, 32'h1);
    step();
    mem_ack = 1'b0;
    dm_req  = 1'b0;
    #1;
    chk("both_gap_mem_req", {31'h0, mem_req}, 32'h0);
    chk("both_stall_if3", {31'h0, stall_if}, 32'h1);
    step();
    chk("both_if_addr", mem_addr, 32'h0000_0100);
    chk("both_if_we", {31'h0, mem_we}, 32'h0);
    chk("both_if_type", {29'h0, mem_type}, 32'h0);
    step();
    step();
    mem_ack   = 1'b1;
    mem_rdata = 32'h00A0_0093;
    #1;
    chk("both_if_ready", {31'h0, if_ready}, 32'h1);
    chk("both_if_rdata", if_rdata, 32'h00A0_0093);
    chk("both_stall_if4", {31'h0, stall_if}, 32'h0);
    step();
    idle_inputs();
    #1;
    chk("both_done", {31'h0, mem_req}, 32'h0);

    // Starvation: both held high, expect 4 DM grants, 1 IF grant, DM again.
    pulse_reset();
    exp_q.push_back(32'h600);
    exp_q.push_back(32'h600);
    exp_q.push_back(32'h600);
    exp_q.push_back(32'h600);
    exp_q.push_back(32'h500);
    exp_q.push_back(32'h600);
    if_req  = 1'b1;
    if_addr = 32'h0000_0500;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h0000_0600;
    for (int g = 0; g < 6; g++) begin
      int n;
      logic [31:0] exp_addr;
      n = 0;
      while (mem_req !== 1'b1 && n < 4) begin
        step();
        n++;
      end
      chk("starve_grant", {31'h0, mem_req}, 32'h1);
      exp_addr = exp_q.pop_front();
      chk("starve_addr", mem_addr, exp_addr);
      mem_ack   = 1'b1;
      mem_rdata = 32'(g);
      step();
      mem_ack = 1'b0;
      #1;
    end
    idle_inputs();
    step();

    // Ack landing on the last allowed cycle: normal completion, no error.
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h0000_0700;
    step();
    for (int k = 0; k < 7; k++) begin
      chk("tack_wait_ready", {31'h0, dm_ready}, 32'h0);
      step();
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h7777_7777;
    #1;
    chk("tack_dm_ready", {31'h0, dm_ready}, 32'h1);
    chk("tack_dm_rdata", dm_rdata, 32'h7777_7777);
    step();
    idle_inputs();
    #1;
    chk("tack_bus_err", {31'h0, bus_err}, 32'h0);
    chk("tack_mem_req", {31'h0, mem_req}, 32'h0);

    // Timeout: load with no ack; ready in the 8th cycle of mem_req, rdata 0.
    dm_req    = 1'b1;
    dm_addr   = 32'h0000_0800;
    mem_rdata = 32'hFFFF_FFFF;
    step();
    chk("to_mem_req", {31'h0, mem_req}, 32'h1);
    for (int k = 0; k < 7; k++) begin
      chk("to_wait_ready", {31'h0, dm_ready}, 32'h0);
      chk("to_wait_err", {31'h0, bus_err}, 32'h0);
      step();
    end
    chk("to_dm_ready", {31'h0, dm_ready}, 32'h1);
    chk("to_dm_rdata", dm_rdata, 32'h0);
    step();
    dm_req = 1'b0;
    #1;
    chk("to_bus_err", {31'h0, bus_err}, 32'h1);
    chk("to_mem_req_low", {31'h0, mem_req}, 32'h0);
    if_req  = 1'b1;
    if_addr = 32'h0000_0900;
    step();
    chk("to_next_addr", mem_addr, 32'h0000_0900);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0013;
    #1;
    chk("to_next_ready", {31'h0, if_ready}, 32'h1);
    chk("to_next_rdata", if_rdata, 32'h0000_0013);
    step();
    idle_inputs();
    #1;
    chk("to_err_sticky", {31'h0, bus_err}, 32'h1);

    // Reset mid DM_BUSY clears mem_req with no clock edge; late ack ignored.
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h0000_0A00;
    dm_wdata = 32'h1234_0000;
    step();
    chk("rmid_mem_req", {31'h0, mem_req}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("rmid_async_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rmid_async_err", {31'h0, bus_err}, 32'h0);
    chk("rmid_async_state", {30'h0, dbg_state}, 32'h0);
    dm_req = 1'b0;
    step();
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0001;
    #1;
    chk("rmid_late_ack_ready", {30'h0, if_ready, dm_ready}, 32'h0);
    chk("rmid_late_ack_rdata", dm_rdata, 32'h0);
    step();
    mem_ack = 1'b0;
    #1;
    chk("rmid_idle_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rmid_idle_state", {30'h0, dbg_state}, 32'h0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
